// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and event packing helpers for the keypad scanner
//
// Contents:
//   state_t     scanner FSM state (IDLE, DRIVE, SAMPLE, NEXT)
//   CNT_W       width of each per-key debounce counter
//   evt_width   event word width from row/column index widths
//   evt_pack    builds {pressed, row_idx, col_idx}
//   evt_pressed / evt_row / evt_col  unpack an event word
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    NEXT   = 2'd3
  } state_t;

  localparam int CNT_W = 3;

  function automatic int evt_width(input int row_w, input int col_w);
    return 1 + row_w + col_w;
  endfunction

  // Result is right-aligned in 32 bits; callers size-cast to their event width.
  function automatic logic [31:0] evt_pack(input logic        pressed,
                                           input logic [15:0] row,
                                           input logic [15:0] col,
                                           input int          row_w,
                                           input int          col_w);
    logic [31:0] v;
    v = {16'd0, col};
    v = v | ({16'd0, row} << col_w);
    v = v | ({31'd0, pressed} << (row_w + col_w));
    return v;
  endfunction

  function automatic logic evt_pressed(input logic [31:0] data, input int row_w, input int col_w);
    return data[row_w + col_w];
  endfunction

  function automatic logic [15:0] evt_row(input logic [31:0] data, input int row_w, input int col_w);
    logic [31:0] mask;
    mask = (32'd1 << row_w) - 32'd1;
    return 16'((data >> col_w) & mask);
  endfunction

  function automatic logic [15:0] evt_col(input logic [31:0] data, input int col_w);
    logic [31:0] mask;
    mask = (32'd1 << col_w) - 32'd1;
    return 16'(data & mask);
  endfunction

endpackage

// File: rtl/keypad_evt_slot.sv
// rtl/keypad_evt_slot.sv - one-entry valid/ready event holding register
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load, load_data write a new entry (taken only while free)
//   ready           consumer accepts the held entry
//   valid, data     held entry; data is stable while valid && !ready
//   free            slot empty or draining this cycle, so a load is accepted
module keypad_evt_slot #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  assign free = ~valid | ready;

  // A load in the same cycle as a drain keeps valid high: back-to-back entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && free) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row-scanning keypad matrix controller with per-key debounce
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   en          scan enable (honoured between rows only)
//   row_n       active-low one-hot row drive, all ones when idle/between rows
//   col_n       raw active-low column inputs (asynchronous)
//   evt_valid   event slot occupied
//   evt_ready   consumer accepts the event
//   evt_data    {pressed, row_idx, col_idx}
//   key_state   debounced state, bit r*COLS+c, 1 = pressed
//   scan_done   one-cycle pulse as the last row finishes
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 4,
  parameter int DB_COUNT = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  output logic [ROWS-1:0]                      row_n,
  input  logic [COLS-1:0]                      col_n,
  output logic                                 evt_valid,
  input  logic                                 evt_ready,
  output logic [$clog2(ROWS)+$clog2(COLS):0]   evt_data,
  output logic [ROWS*COLS-1:0]                 key_state,
  output logic                                 scan_done
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int EVT_W = evt_width(ROW_W, COL_W);
  localparam int KEYS  = ROWS * COLS;
  localparam int KEY_W = $clog2(KEYS);
  localparam int SET_W = $clog2(SETTLE);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_COUNT - 1);

  state_t             state, state_d;
  logic [ROW_W-1:0]   row, row_d;
  logic [COL_W-1:0]   col, col_d;
  logic [SET_W-1:0]   settle_cnt, settle_d;
  logic [COLS-1:0]    col_s1, col_s2;
  logic [CNT_W-1:0]   db_cnt [KEYS];
  logic [KEY_W-1:0]   key_idx;

  logic               sample;
  logic               flip_due;
  logic               commit;
  logic               cnt_inc;
  logic               cnt_clr;
  logic               slot_free;
  logic [EVT_W-1:0]   load_data;

  assign key_idx = KEY_W'(row) * KEY_W'(COLS) + KEY_W'(col);

  // Synchronizer resets to all ones so no key appears closed out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_d;
      row        <= row_d;
      col        <= col_d;
      settle_cnt <= settle_d;
    end
  end

  always_comb begin
    state_d   = state;
    row_d     = row;
    col_d     = col;
    settle_d  = settle_cnt;
    row_n     = '1;
    scan_done = 1'b0;
    sample    = 1'b0;
    flip_due  = 1'b0;
    commit    = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_d  = DRIVE;
          row_d    = '0;
          settle_d = '0;
        end
      end
      DRIVE: begin
        row_n[row] = 1'b0;
        if (settle_cnt == SET_LAST) begin
          state_d  = SAMPLE;
          col_d    = '0;
          settle_d = '0;
        end else begin
          settle_d = settle_cnt + 1'b1;
        end
      end
      SAMPLE: begin
        row_n[row] = 1'b0;
        sample     = ~col_s2[col];
        if (sample == key_state[key_idx]) begin
          cnt_clr = 1'b1;
        end else if (db_cnt[key_idx] == DB_LAST) begin
          flip_due = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
        commit = flip_due && slot_free;
        // A due flip with no room in the slot freezes the scan on this key.
        if (!flip_due || slot_free) begin
          if (col == COL_LAST) begin
            state_d = NEXT;
          end else begin
            col_d = col + 1'b1;
          end
        end
      end
      NEXT: begin
        scan_done = (row == ROW_LAST);
        row_d     = (row == ROW_LAST) ? '0 : row + 1'b1;
        state_d   = en ? DRIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_state <= '0;
      for (int i = 0; i < KEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else if (commit) begin
      key_state[key_idx] <= sample;
      db_cnt[key_idx]    <= '0;
    end else if (cnt_clr) begin
      db_cnt[key_idx] <= '0;
    end else if (cnt_inc) begin
      db_cnt[key_idx] <= db_cnt[key_idx] + 1'b1;
    end
  end

  assign load_data = EVT_W'(evt_pack(sample, 16'(row), 16'(col), ROW_W, COL_W));

  keypad_evt_slot #(
    .W (EVT_W)
  ) u_evt_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (commit),
    .load_data (load_data),
    .ready     (evt_ready),
    .valid     (evt_valid),
    .data      (evt_data),
    .free      (slot_free)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        evt_valid;
  logic        evt_ready;
  logic [4:0]  evt_data;
  logic [15:0] key_state;
  logic        scan_done;
  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_scanner #(
    .ROWS     (4),
    .COLS     (4),
    .SETTLE   (4),
    .DB_COUNT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .row_n     (row_n),
    .col_n     (col_n),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .key_state (key_state),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_count(input int n, output int cnt, output int first, output logic [4:0] first_data);
    cnt = 0;
    first = -1;
    first_data = '0;
    for (int j = 0; j < n; j++) begin
      if (evt_valid) begin
        if (cnt == 0) begin
          first = j;
          first_data = evt_data;
        end
        cnt++;
      end
      step();
    end
  endtask

  initial begin
    int          cnt;
    int          cnt2;
    int          first;
    logic [4:0]  fdata;
    logic [3:0]  exp_row;
    int          p;

    rst = 1'b1;
    en = 1'b0;
    evt_ready = 1'b1;
    keys = '0;
    step(); step(); step();
    check("rst_row_n", 32'(row_n), 32'hF);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_data", 32'(evt_data), 32'd0);
    check("rst_key_state", 32'(key_state), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);

    // Idle scan: row k low for 8 cycles, 1-cycle gap, scan_done every 36.
    rst = 1'b0;
    en = 1'b1;
    step();
    for (int k = 0; k < 72; k++) begin
      p = k % 36;
      exp_row = 4'hF;
      if ((p % 9) != 8) exp_row[p/9] = 1'b0;
      check($sformatf("scan_row_n_k%0d", k), 32'(row_n), 32'(exp_row));
      check($sformatf("scan_done_k%0d", k), 32'(scan_done), (p == 35) ? 32'd1 : 32'd0);
      check($sformatf("scan_no_evt_k%0d", k), 32'(evt_valid), 32'd0);
      step();
    end

    // Key (2,1) press: sampled at scan offset 23, third disagreement commits.
    keys[9] = 1'b1;
    run_count(180, cnt, first, fdata);
    check("press21_count", 32'(cnt), 32'd1);
    check("press21_time", 32'(first), 32'd96);
    check("press21_data", 32'(fdata), 32'h19);
    check("press21_state", 32'(key_state), 32'h0200);

    keys[9] = 1'b0;
    run_count(180, cnt, first, fdata);
    check("rel21_count", 32'(cnt), 32'd1);
    check("rel21_time", 32'(first), 32'd96);
    check("rel21_data", 32'(fdata), 32'h09);
    check("rel21_state", 32'(key_state), 32'h0000);

    // Key (0,0) closed for only two scans.
    keys[0] = 1'b1;
    run_count(72, cnt, first, fdata);
    keys[0] = 1'b0;
    run_count(108, cnt2, first, fdata);
    check("glitch_count", 32'(cnt + cnt2), 32'd0);
    check("glitch_state", 32'(key_state), 32'h0000);

    // Keys (1,0) and (1,3) with the consumer stalled.
    evt_ready = 1'b0;
    keys[4] = 1'b1;
    keys[7] = 1'b1;
    run_count(86, cnt, first, fdata);
    check("stall_pre_count", 32'(cnt), 32'd0);
    check("stall_first_valid", 32'(evt_valid), 32'd1);
    check("stall_first_data", 32'(evt_data), 32'h14);
    check("stall_first_state", 32'(key_state), 32'h0010);
    for (int j = 86; j <= 136; j++) begin
      check($sformatf("stall_hold_j%0d", j), {22'd0, evt_valid, evt_data, row_n}, {22'd0, 1'b1, 5'h14, 4'b1101});
      check($sformatf("stall_no_done_j%0d", j), 32'(scan_done), 32'd0);
      if (j != 136) step();
    end
    evt_ready = 1'b1;
    step();
    check("b2b_valid", 32'(evt_valid), 32'd1);
    check("b2b_data", 32'(evt_data), 32'h17);
    check("b2b_next_row_n", 32'(row_n), 32'hF);
    check("b2b_state", 32'(key_state), 32'h0090);
    step();
    check("b2b_drained", 32'(evt_valid), 32'd0);
    check("b2b_row2_row_n", 32'(row_n), 32'b1011);

    // Drop en one cycle into the DRIVE of row 2.
    step();
    en = 1'b0;
    repeat (6) step();
    check("en_row2_last_sample", 32'(row_n), 32'b1011);
    step();
    check("en_next_row_n", 32'(row_n), 32'hF);
    check("en_next_state", 32'(dut.state), 32'(NEXT));
    step();
    check("en_idle_state", 32'(dut.state), 32'(IDLE));
    repeat (5) step();
    check("en_idle_hold", 32'(dut.state), 32'(IDLE));
    check("en_idle_row_n", 32'(row_n), 32'hF);
    check("en_idle_keys", 32'(key_state), 32'h0090);

    // Restart, release both keys with the consumer stalled, then reset.
    evt_ready = 1'b0;
    keys = '0;
    en = 1'b1;
    step();
    check("restart_row0", 32'(row_n), 32'b1110);
    repeat (86) step();
    check("rel10_valid", 32'(evt_valid), 32'd1);
    check("rel10_data", 32'(evt_data), 32'h04);
    check("rel10_state", 32'(key_state), 32'h0080);
    repeat (10) step();
    check("rel_stall_row_n", 32'(row_n), 32'b1101);
    check("rel_stall_valid", 32'(evt_valid), 32'd1);
    check("rel_stall_data", 32'(evt_data), 32'h04);
    rst = 1'b1;
    step();
    check("midrst_valid", 32'(evt_valid), 32'd0);
    check("midrst_data", 32'(evt_data), 32'd0);
    check("midrst_keys", 32'(key_state), 32'd0);
    check("midrst_row_n", 32'(row_n), 32'hF);
    check("midrst_done", 32'(scan_done), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
